// File: rtl/tt_trace_pkg.sv
// Shared types and constants for the IO trace monitor and its FIFO.
package tt_trace_pkg;

  typedef enum logic [1:0] {
    MODE_OFF         = 2'd0,
    MODE_EVERY       = 2'd1,
    MODE_CHANGE      = 2'd2,
    MODE_TRIG_CHANGE = 2'd3
  } trace_mode_t;

  localparam logic [7:0] OVF_SAT = 8'hFF;

  function automatic int recWidth(input int channels, input int tsW);
    return channels * 8 + tsW;
  endfunction

endpackage

// File: rtl/tt_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry an extra wrap bit.
module tt_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o = wrPtr_q - rdPtr_q;
  // Empty reads return zero so the head is clean after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    doPop   = pop_i && !empty_o;
    doPush  = push_i && (!full_o || doPop);
    wrPtr_d = wrPtr_q + {{AW{1'b0}}, doPush};
    rdPtr_d = rdPtr_q + {{AW{1'b0}}, doPop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/tt_io_trace_monitor.sv
// Samples CPU output buses into timestamped records, drained over valid/ready.
module tt_io_trace_monitor
  import tt_trace_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 16,
  parameter int TS_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [7:0]                 trig_mask,
  input  logic [7:0]                 trig_value,
  input  logic [CHANNELS*8-1:0]      mon_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CHANNELS*8+TS_W-1:0] rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [7:0]                 overflow_cnt,
  output logic                       triggered
);

  localparam int DataW = CHANNELS * 8;
  localparam int RecW  = recWidth(CHANNELS, TS_W);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [DataW-1:0] last_q, last_d;
  logic             first_q, first_d;
  logic             enPrev_q;
  logic [1:0]       modePrev_q;
  logic             triggered_q, triggered_d;
  logic [7:0]       ovf_q, ovf_d;

  trace_mode_t curMode;
  logic        match, firstNow, changed, capture, pop, drop, full, empty;
  logic [RecW-1:0] record;

  assign curMode = trace_mode_t'(mode);

  // The first flag is re-armed combinationally so a rising en or mode write captures that same cycle.
  always_comb begin
    match       = ((mon_data[7:0] & trig_mask) == (trig_value & trig_mask));
    firstNow    = first_q || (en && !enPrev_q) || (mode != modePrev_q);
    changed     = (mon_data != last_q) || firstNow;
    capture     = 1'b0;
    case (curMode)
      MODE_EVERY:       capture = en;
      MODE_CHANGE:      capture = en && changed;
      MODE_TRIG_CHANGE: capture = en && changed && (triggered_q || match);
      default:          capture = 1'b0;
    endcase
    pop         = !empty && rd_ready;
    drop        = capture && full && !pop;
    first_d     = firstNow && !capture;
    triggered_d = (curMode == MODE_TRIG_CHANGE) && (triggered_q || match);
    ovf_d       = (drop && ovf_q != OVF_SAT) ? ovf_q + 8'd1 : ovf_q;
    last_d      = en ? mon_data : last_q;
    ts_d        = ts_q + {{(TS_W-1){1'b0}}, 1'b1};
    record      = {ts_q, mon_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q        <= '0;
      last_q      <= '0;
      first_q     <= 1'b1;
      enPrev_q    <= 1'b0;
      modePrev_q  <= MODE_OFF;
      triggered_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      ts_q        <= ts_d;
      last_q      <= last_d;
      first_q     <= first_d;
      enPrev_q    <= en;
      modePrev_q  <= mode;
      triggered_q <= triggered_d;
      ovf_q       <= ovf_d;
    end
  end

  tt_sync_fifo #(
    .WIDTH (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .wdata_i (record),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .rdata_o (rd_data),
    .count_o (count)
  );

  assign rd_valid     = !empty;
  assign overflow_cnt = ovf_q;
  assign triggered    = triggered_q;

endmodule

// File: tb/tb_tt_io_trace_monitor.sv
// Directed bench: expected records queued as stimulus is driven, compared as the FIFO drains.
module tb_tt_io_trace_monitor;
  import tt_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, rdReady;
  logic [1:0]  mode;
  logic [7:0]  trigMask, trigValue;
  logic [23:0] monData;

  logic        rdValid, rdValid2, trig, trig2;
  logic [39:0] rdData;
  logic [27:0] rdData2;
  logic [4:0]  count, count2;
  logic [7:0]  ovf, ovf2;

  typedef struct {
    int          ts;
    logic [23:0] data;
  } rec_t;

  rec_t sb[$];
  int   numChecks  = 0;
  int   numFails   = 0;
  int   cycleCount = 0;

  always #5 clk = ~clk;

  tt_io_trace_monitor dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .trig_mask(trigMask), .trig_value(trigValue), .mon_data(monData),
    .rd_ready(rdReady), .rd_valid(rdValid), .rd_data(rdData),
    .count(count), .overflow_cnt(ovf), .triggered(trig)
  );

  tt_io_trace_monitor #(.TS_W(4)) dutTs (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .trig_mask(trigMask), .trig_value(trigValue), .mon_data(monData),
    .rd_ready(rdReady), .rd_valid(rdValid2), .rd_data(rdData2),
    .count(count2), .overflow_cnt(ovf2), .triggered(trig2)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cycleCount++;
  endtask

  task automatic applyStimulus(input logic enV, input logic [1:0] modeV,
                               input logic [23:0] dataV, input logic readyV);
    en      = enV;
    mode    = modeV;
    monData = dataV;
    rdReady = readyV;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numChecks++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus(1'b0, MODE_OFF, 24'h0, 1'b0);
    step();
    step();
    rst = 1'b0;
    cycleCount = 0;
  endtask

  task automatic expectCapture(input logic [23:0] data);
    rec_t r;
    r.ts   = cycleCount;
    r.data = data;
    sb.push_back(r);
  endtask

  // Pops every queued record from the main instance with rd_ready held high.
  task automatic drainCheck(input string tag);
    rec_t r;
    int   n;
    en      = 1'b0;
    rdReady = 1'b1;
    n       = sb.size();
    for (int i = 0; i < n; i++) begin
      r = sb.pop_front();
      checkOutput({tag, "_valid"}, 64'(rdValid), 64'd1);
      checkOutput({tag, "_data"}, 64'(rdData), 64'({r.ts[15:0], r.data}));
      step();
    end
    checkOutput({tag, "_empty"}, 64'(rdValid), 64'd0);
    checkOutput({tag, "_count0"}, 64'(count), 64'd0);
    rdReady = 1'b0;
  endtask

  initial begin
    rec_t r;
    trigMask  = 8'h00;
    trigValue = 8'h00;
    applyStimulus(1'b0, MODE_OFF, 24'h0, 1'b0);

    // Reset state
    rst = 1'b1;
    step();
    step();
    checkOutput("rst_valid", 64'(rdValid), 64'd0);
    checkOutput("rst_data", 64'(rdData), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_trig", 64'(trig), 64'd0);
    rst = 1'b0;
    cycleCount = 0;

    // EVERY for five cycles, then hold and drain
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, MODE_EVERY, 24'(i + 1), 1'b0);
      expectCapture(monData);
      step();
    end
    en = 1'b0;
    checkOutput("every_count", 64'(count), 64'd5);
    r = sb[0];
    checkOutput("every_head", 64'(rdData), 64'({r.ts[15:0], r.data}));
    step();
    checkOutput("every_hold", 64'(rdData), 64'({r.ts[15:0], r.data}));
    drainCheck("every");

    // CHANGE: first sample plus one change
    applyStimulus(1'b1, MODE_CHANGE, 24'hA5A5A5, 1'b0);
    expectCapture(monData);
    repeat (10) step();
    monData = 24'hA5A5A6;
    expectCapture(monData);
    step();
    en = 1'b0;
    checkOutput("change_count", 64'(count), 64'd2);
    drainCheck("change");

    // TRIG_CHANGE with channel 0 sweeping 00..07
    trigMask  = 8'h0F;
    trigValue = 8'h03;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, MODE_TRIG_CHANGE, {16'h1234, 8'(i)}, 1'b0);
      if (i >= 3) expectCapture(monData);
      step();
      checkOutput($sformatf("trig_flag_%0d", i), 64'(trig), (i >= 3) ? 64'd1 : 64'd0);
    end
    en = 1'b0;
    checkOutput("trig_count", 64'(count), 64'd5);
    drainCheck("trig");
    checkOutput("trig_sticky", 64'(trig), 64'd1);

    // EVERY into a full FIFO: 16 kept, 4 dropped
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, MODE_EVERY, {8'hC0, 8'h00, 8'(i)}, 1'b0);
      if (i < 16) expectCapture(monData);
      step();
      if (i == 0) checkOutput("trig_cleared", 64'(trig), 64'd0);
    end
    checkOutput("full_count", 64'(count), 64'd16);
    checkOutput("full_ovf", 64'(ovf), 64'd4);
    r = sb[0];
    checkOutput("full_head", 64'(rdData), 64'({r.ts[15:0], r.data}));

    // Full with simultaneous push and pop
    for (int i = 0; i < 6; i++) begin
      r = sb.pop_front();
      checkOutput($sformatf("fullpp_data_%0d", i), 64'(rdData), 64'({r.ts[15:0], r.data}));
      applyStimulus(1'b1, MODE_EVERY, {8'hD0, 8'h00, 8'(i)}, 1'b1);
      expectCapture(monData);
      step();
      checkOutput($sformatf("fullpp_count_%0d", i), 64'(count), 64'd16);
      checkOutput($sformatf("fullpp_ovf_%0d", i), 64'(ovf), 64'd4);
    end
    drainCheck("fullpp");

    // Narrow timestamp wraps while draining, then reset mid-drain
    applyReset();
    sb.delete();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, MODE_EVERY, {8'hE0, 8'h00, 8'(i)}, 1'b1);
      expectCapture(monData);
      step();
      r = sb.pop_front();
      checkOutput($sformatf("wrap_valid_%0d", i), 64'(rdValid2), 64'd1);
      checkOutput($sformatf("wrap_data_%0d", i), 64'(rdData2), 64'({r.ts[3:0], r.data}));
    end
    rdReady = 1'b0;
    repeat (3) step();
    checkOutput("wrap_count", 64'(count2), 64'd4);
    rst = 1'b1;
    step();
    checkOutput("midrst_valid", 64'(rdValid2), 64'd0);
    checkOutput("midrst_count", 64'(count2), 64'd0);
    checkOutput("midrst_ovf", 64'(ovf2), 64'd0);
    checkOutput("midrst_trig", 64'(trig2), 64'd0);
    checkOutput("midrst_main_valid", 64'(rdValid), 64'd0);
    checkOutput("midrst_main_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
